// File: rtl/gamma_module_v3_pkg.sv
// Shared video parameters for the gamma block: selector encoding,
// table latency and the selector decode helper.
package gamma_module_v3_pkg;

   localparam int GAMMA_SEL_W   = 4;
   localparam int GAMMA_PAGE_W  = 3;
   localparam int GAMMA_TBL_LAT = 2;

   // Selector value that routes pixels around the table. Values below it
   // map straight to a page, values above it map to value-1.
   localparam logic [GAMMA_SEL_W-1:0] GAMMA_TABLE_OFF = 4'd4;

   typedef struct packed {
      logic                    nbypass;
      logic [GAMMA_PAGE_W-1:0] page;
   } gamma_sel_t;

   function automatic gamma_sel_t gamma_decode(input logic [GAMMA_SEL_W-1:0] sel);
      gamma_sel_t d;
      d.nbypass = (sel != GAMMA_TABLE_OFF);
      if (sel < GAMMA_TABLE_OFF)
         d.page = sel[GAMMA_PAGE_W-1:0];
      else if (sel == GAMMA_TABLE_OFF)
         d.page = '0;
      else if (sel > 4'd8)
         d.page = 3'd7;
      else
         d.page = 3'(sel - 4'd1);
      return d;
   endfunction

endpackage

// File: rtl/gamma_table_v3.sv
// Gamma ROM: eight curve pages blending linear into square law, plus an
// MSB-replicating bypass. Two register stages, bypass matches table latency.
module gamma_table_v3
   import gamma_module_v3_pkg::*;
#(
   parameter int COLOR_W_I = 7,
   parameter int COLOR_W_O = 8
) (
   input  logic                    VCLK,
   input  logic                    nRST,
   input  logic [GAMMA_PAGE_W-1:0] page,
   input  logic                    nbypass,
   input  logic [COLOR_W_I-1:0]    din,
   output logic [COLOR_W_O-1:0]    dout
);

   localparam int PW = 2*COLOR_W_O + 4;

   logic [COLOR_W_O-1:0] lut_q  = '0;
   logic [COLOR_W_O-1:0] dout_q = '0;

   // Page p bends the left-aligned linear ramp (p+1)/8 of the way toward x^2.
   function automatic logic [COLOR_W_O-1:0] curve(input logic [GAMMA_PAGE_W-1:0] pg,
                                                  input logic [COLOR_W_I-1:0] x);
      logic [PW-1:0] lin, sq, bend;
      lin  = PW'(x) << (COLOR_W_O-COLOR_W_I);
      sq   = (PW'(x) * PW'(x)) >> (2*COLOR_W_I-COLOR_W_O);
      bend = ((lin - sq) * (PW'(pg) + PW'(1))) >> 3;
      return COLOR_W_O'(lin - bend);
   endfunction

   // Left-align and refill the low bits from the top of the channel.
   function automatic logic [COLOR_W_O-1:0] expand(input logic [COLOR_W_I-1:0] x);
      logic [COLOR_W_O-1:0] r;
      r = '0;
      for (int i = 0; i < COLOR_W_O; i++)
         r[COLOR_W_O-1-i] = x[COLOR_W_I-1-(i % COLOR_W_I)];
      return r;
   endfunction

   // Lookup stage then output stage.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         lut_q  <= '0;
         dout_q <= '0;
      end else begin
         lut_q  <= nbypass ? curve(page, din) : expand(din);
         dout_q <= lut_q;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/gamma_module_v3.sv
// Gamma sequencer: latches a pixel on its strobe, feeds one channel per
// cycle through gamma_table_v3 and reassembles the corrected pixel.
module gamma_module_v3
   import gamma_module_v3_pkg::*;
#(
   parameter int COLOR_W_I = 7,
   parameter int COLOR_W_O = 8,
   parameter int N_CH      = 3,
   parameter int SYNC_W    = 4
) (
   input  logic                            VCLK,
   input  logic                            nRST,
   input  logic [GAMMA_SEL_W-1:0]          gammaparams_i,
   input  logic                            vdata_valid_i,
   input  logic [SYNC_W+N_CH*COLOR_W_I-1:0] vdata_i,
   output logic                            vdata_valid_o,
   output logic [SYNC_W+N_CH*COLOR_W_O-1:0] vdata_o,
   output logic                            pixel_drop_o
);

   localparam int               CNT_W   = $clog2(N_CH);
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(N_CH-1);

   // Tag travelling beside each channel through the table.
   typedef struct packed {
      logic              vld;
      logic [CNT_W-1:0]  ch;
      logic [SYNC_W-1:0] sync;
   } tag_t;

   logic [GAMMA_SEL_W-1:0]             sel_raw_q = GAMMA_TABLE_OFF;
   logic [SYNC_W-1:0]                  sync_q    = '0;
   logic [N_CH-1:0][COLOR_W_I-1:0]     pix_q     = '0;
   logic                               busy      = 1'b0;
   logic [CNT_W-1:0]                   cnt       = '0;
   logic                               abort_q   = 1'b0;
   logic                               drop_q    = 1'b0;
   logic [COLOR_W_I-1:0]               tin_data  = '0;
   gamma_sel_t                         tin_sel   = '0;
   tag_t [GAMMA_TBL_LAT:0]             tag_pipe  = '0;
   logic [N_CH-1:0][COLOR_W_O-1:0]     stage     = '0;
   logic [SYNC_W+N_CH*COLOR_W_O-1:0]   vout_q    = '0;
   logic                               vvld_q    = 1'b0;

   logic                               abort, issue;
   logic [COLOR_W_O-1:0]               tout_data;
   tag_t                               tout;
   logic [N_CH-1:0][COLOR_W_O-1:0]     stage_nx;

   // A strobe before the last channel has issued kills the old pixel.
   assign abort = vdata_valid_i && busy && (cnt != LAST_CH);
   assign issue = busy && !abort;
   assign tout  = tag_pipe[GAMMA_TBL_LAT];

   // Strobe capture and input channel counter; drop pulse one cycle late.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         sel_raw_q <= GAMMA_TABLE_OFF;
         sync_q    <= '0;
         pix_q     <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
         abort_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         abort_q <= abort;
         drop_q  <= abort_q;
         if (vdata_valid_i) begin
            sel_raw_q <= gammaparams_i;
            sync_q    <= vdata_i[SYNC_W+N_CH*COLOR_W_I-1 -: SYNC_W];
            pix_q     <= vdata_i[N_CH*COLOR_W_I-1:0];
            busy      <= 1'b1;
            cnt       <= '0;
         end else if (busy) begin
            if (cnt == LAST_CH) busy <= 1'b0;
            else                cnt  <= cnt + CNT_W'(1);
         end
      end
   end

   // Table input register and tag delay line matched to table latency.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         tin_data <= '0;
         tin_sel  <= '0;
         tag_pipe <= '0;
      end else begin
         tin_data    <= pix_q[cnt];
         tin_sel     <= gamma_decode(sel_raw_q);
         tag_pipe[0] <= '{vld: issue, ch: cnt, sync: sync_q};
         for (int i = 1; i <= GAMMA_TBL_LAT; i++)
            tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   gamma_table_v3 #(
      .COLOR_W_I (COLOR_W_I),
      .COLOR_W_O (COLOR_W_O)
   ) u_table (
      .VCLK    (VCLK),
      .nRST    (nRST),
      .page    (tin_sel.page),
      .nbypass (tin_sel.nbypass),
      .din     (tin_data),
      .dout    (tout_data)
   );

   // Staging with the arriving channel merged in.
   always_comb begin
      stage_nx = stage;
      if (tout.vld) stage_nx[tout.ch] = tout_data;
   end

   // Collect channels; publish the pixel when its last channel lands.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         stage  <= '0;
         vout_q <= '0;
         vvld_q <= 1'b0;
      end else begin
         stage  <= stage_nx;
         vvld_q <= tout.vld && (tout.ch == LAST_CH);
         if (tout.vld && (tout.ch == LAST_CH))
            vout_q <= {tout.sync, stage_nx};
      end
   end

   assign vdata_valid_o = vvld_q;
   assign vdata_o       = vout_q;
   assign pixel_drop_o  = drop_q;

endmodule

// File: tb/tb_gamma_module_v3.sv
// Bench for gamma_module_v3: fixed vectors, hand sequences for abort/reset,
// and a randomized run checked every cycle against a timing scoreboard.
module tb_gamma_module_v3;

   localparam int NC = 3, WI = 7, WO = 8, SW = 4;
   localparam int IW = SW + NC*WI, OW = SW + NC*WO;
   localparam int LAT = NC + 3;

   logic          VCLK = 1'b0;
   logic          nRST;
   logic [3:0]    vin_sel;
   logic          vin_valid;
   logic [IW-1:0] vin_data;
   logic          vout_valid, vout_drop;
   logic [OW-1:0] vout_data;

   logic [3:0]    v4_sel;
   logic          v4_valid;
   logic [35:0]   v4_data;
   logic          v4_out_valid, v4_drop;
   logic [43:0]   v4_out_data;

   int n_err = 0, n_chk = 0;
   int cyc = 0, last_rst = -1, pend_cyc = 0;
   bit have_pend = 0;
   int n_vld = 0, n_drop = 0;
   logic [OW-1:0] hold = '0;
   logic [OW-1:0] exp_val [int];
   bit            exp_drop [int];

   always #5 VCLK = ~VCLK;

   gamma_module_v3 dut (
      .VCLK(VCLK), .nRST(nRST), .gammaparams_i(vin_sel), .vdata_valid_i(vin_valid),
      .vdata_i(vin_data), .vdata_valid_o(vout_valid), .vdata_o(vout_data),
      .pixel_drop_o(vout_drop));

   gamma_module_v3 #(.COLOR_W_I(8), .COLOR_W_O(10), .N_CH(4), .SYNC_W(4)) dut4 (
      .VCLK(VCLK), .nRST(nRST), .gammaparams_i(v4_sel), .vdata_valid_i(v4_valid),
      .vdata_i(v4_data), .vdata_valid_o(v4_out_valid), .vdata_o(v4_out_data),
      .pixel_drop_o(v4_drop));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference channel: bypass = left-align plus top bits; page p moves
   // (p+1)/8 of the way from the linear ramp to x^2.
   function automatic int model_ch(input int sel, input int x, input int wi, input int wo);
      int page, lin, sq;
      lin = x << (wo - wi);
      if (sel == 4) return lin | (x >> (2*wi - wo));
      page = (sel < 4) ? sel : (sel > 8) ? 7 : sel - 1;
      sq   = (x * x) >> (2*wi - wo);
      return lin - ((lin - sq) * (page + 1)) / 8;
   endfunction

   function automatic logic [OW-1:0] model_px(input logic [3:0] sel, input logic [IW-1:0] d);
      logic [OW-1:0] r;
      r[OW-1 -: SW] = d[IW-1 -: SW];
      for (int k = 0; k < NC; k++)
         r[k*WO +: WO] = WO'(model_ch(int'(sel), int'(d[k*WI +: WI]), WI, WO));
      return r;
   endfunction

   // Scoreboard: every accepted strobe predicts its pixel LAT edges later;
   // a strobe fewer than NC cycles after the previous one cancels it.
   always @(posedge VCLK) begin
      cyc = cyc + 1;
      if (!nRST) begin
         exp_val.delete();
         exp_drop.delete();
         last_rst = cyc;
         have_pend = 0;
      end else if (vin_valid) begin
         if (have_pend && (cyc - pend_cyc) < NC) begin
            exp_drop[cyc+1] = 1'b1;
            if (exp_val.exists(pend_cyc + LAT)) exp_val.delete(pend_cyc + LAT);
         end
         exp_val[cyc + LAT] = model_px(vin_sel, vin_data);
         have_pend = 1;
         pend_cyc  = cyc;
      end
   end

   // Per-cycle comparison of the default instance against the scoreboard.
   always @(negedge VCLK) begin
      bit ev, ed;
      ev = exp_val.exists(cyc) && (last_rst != cyc);
      ed = exp_drop.exists(cyc) && (last_rst != cyc);
      if (last_rst == cyc) hold = '0;
      else if (ev)         hold = exp_val[cyc];
      chk("sb_valid", 64'(vout_valid), 64'(ev));
      chk("sb_data",  64'(vout_data),  64'(hold));
      chk("sb_drop",  64'(vout_drop),  64'(ed));
      if (vout_valid) n_vld++;
      if (vout_drop)  n_drop++;
   end

   // Called at a negedge: strobe sampled on the next rising edge.
   task automatic pulse(input logic [3:0] sel, input logic [IW-1:0] d);
      vin_sel = sel; vin_data = d; vin_valid = 1'b1;
      @(negedge VCLK);
      vin_valid = 1'b0;
      vin_sel = 4'($urandom_range(0, 15));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         vin_sel = 4'($urandom_range(0, 15));
         @(negedge VCLK);
      end
   endtask

   function automatic logic [IW-1:0] rnd_px();
      return IW'({$urandom, $urandom});
   endfunction

   typedef struct {
      logic [3:0] sel; logic [3:0] sync;
      logic [6:0] c0, c1, c2;
      logic [7:0] e0, e1, e2;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [IW-1:0] px;
      vecs[0] = '{4'd4,  4'hA, 7'h7F, 7'h00, 7'h40, 8'hFF, 8'h00, 8'h81};
      vecs[1] = '{4'd0,  4'h3, 7'h40, 7'h20, 7'h10, 8'h78, 8'h3A, 8'h1D};
      vecs[2] = '{4'd5,  4'h5, 7'h20, 7'h40, 7'h7F, 8'h22, 8'h58, 8'hFD};
      vecs[3] = '{4'd12, 4'hF, 7'h7F, 7'h40, 7'h20, 8'hFC, 8'h40, 8'h10};
      vecs[4] = '{4'd3,  4'h0, 7'h7F, 7'h40, 7'h00, 8'hFD, 8'h60, 8'h00};
      vecs[5] = '{4'd9,  4'h6, 7'h10, 7'h40, 7'h7F, 8'h04, 8'h40, 8'hFC};
      vecs[6] = '{4'd8,  4'hC, 7'h20, 7'h20, 7'h20, 8'h10, 8'h10, 8'h10};
      vecs[7] = '{4'd4,  4'h1, 7'h01, 7'h2A, 7'h55, 8'h02, 8'h54, 8'hAB};

      nRST = 1'b0; vin_sel = 4'd4; vin_valid = 1'b0; vin_data = '0;
      v4_sel = 4'd4; v4_valid = 1'b0; v4_data = '0;
      repeat (3) @(negedge VCLK);
      chk("rst_valid", 64'(vout_valid), 64'd0);
      chk("rst_data",  64'(vout_data),  64'd0);
      chk("rst_drop",  64'(vout_drop),  64'd0);
      chk("rst4_data", 64'(v4_out_data), 64'd0);
      nRST = 1'b1;
      idle(2);

      // Fixed vectors: bypass, page decode boundaries.
      foreach (vecs[i]) begin
         pulse(vecs[i].sel, {vecs[i].sync, vecs[i].c2, vecs[i].c1, vecs[i].c0});
         idle(5);
         chk($sformatf("vec%0d_early", i), 64'(vout_valid), 64'd0);
         idle(1);
         chk($sformatf("vec%0d_valid", i), 64'(vout_valid), 64'd1);
         chk($sformatf("vec%0d_data", i), 64'(vout_data),
             64'({vecs[i].sync, vecs[i].e2, vecs[i].e1, vecs[i].e0}));
         idle(2);
      end

      // Same pixel through selector 0 and GAMMA_TABLE_OFF+1.
      n_vld = 0;
      px = rnd_px();
      pulse(4'd0, px); idle(8);
      pulse(4'd5, px); idle(8);
      chk("pagesel_pulses", 64'(n_vld), 64'd2);

      // Back-to-back strobes every NC cycles.
      n_vld = 0; n_drop = 0;
      for (int i = 0; i < 10; i++) begin
         pulse(4'($urandom_range(0, 15)), rnd_px());
         idle(NC - 1);
      end
      idle(8);
      chk("b2b_pulses", 64'(n_vld), 64'd10);
      chk("b2b_drops",  64'(n_drop), 64'd0);

      // Abort: second strobe one cycle after the first.
      n_vld = 0; n_drop = 0;
      pulse(4'd4, rnd_px());
      pulse(4'd2, rnd_px());
      idle(8);
      chk("abort1_drops",  64'(n_drop), 64'd1);
      chk("abort1_pulses", 64'(n_vld), 64'd1);

      // Abort two cycles after.
      n_vld = 0; n_drop = 0;
      pulse(4'd7, rnd_px()); idle(1);
      pulse(4'd1, rnd_px()); idle(8);
      chk("abort2_drops",  64'(n_drop), 64'd1);
      chk("abort2_pulses", 64'(n_vld), 64'd1);

      // Reset for one cycle at t+2 mid-pixel.
      n_vld = 0;
      pulse(4'd4, rnd_px()); idle(1);
      nRST = 1'b0;
      @(negedge VCLK);
      chk("midrst_valid", 64'(vout_valid), 64'd0);
      chk("midrst_data",  64'(vout_data),  64'd0);
      chk("midrst_drop",  64'(vout_drop),  64'd0);
      nRST = 1'b1;
      idle(10);
      chk("midrst_quiet", 64'(n_vld), 64'd0);
      pulse(4'd6, rnd_px()); idle(8);
      chk("midrst_fresh", 64'(n_vld), 64'd1);

      // Randomized traffic with mixed gaps (some abort).
      for (int i = 0; i < 60; i++) begin
         pulse(4'($urandom_range(0, 15)), rnd_px());
         idle($urandom_range(0, 5));
      end
      idle(10);

      // Wider instance: 4 channels, 8 -> 10 bit bypass.
      v4_sel = 4'd4; v4_data = {4'h9, 32'hA5A5A5A5}; v4_valid = 1'b1;
      @(negedge VCLK);
      v4_valid = 1'b0;
      repeat (6) @(negedge VCLK);
      chk("w4_early", 64'(v4_out_valid), 64'd0);
      @(negedge VCLK);
      chk("w4_valid", 64'(v4_out_valid), 64'd1);
      chk("w4_data",  64'(v4_out_data), 64'({4'h9, 10'h296, 10'h296, 10'h296, 10'h296}));
      @(negedge VCLK);
      chk("w4_once",  64'(v4_out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/gamma_module_v3.md
GAMMA_MODULE_V3 -- requirements
Module: gamma_module_v3

Interface
REQ-001 Parameter COLOR_W_I, default 7, input bits per colour channel.
REQ-002 Parameter COLOR_W_O, default 8, output bits per colour channel (COLOR_W_O >= COLOR_W_I).
REQ-003 Parameter N_CH, default 3, colour channels per pixel (2..4); channel 0 in the LSBs of the colour field.
REQ-004 Parameter SYNC_W, default 4, sync bits carried alongside colour.
REQ-005 VCLK  in  1  sole clock; all state on rising edge.
REQ-006 nRST  in  1  reset, synchronous, active-low.
REQ-007 gammaparams_i  in  4  gamma selector, sampled only on vdata_valid_i.
REQ-008 vdata_valid_i  in  1  one-cycle strobe marking a new pixel; vdata_i held stable for N_CH cycles from the strobe.
REQ-009 vdata_i  in  SYNC_W+N_CH*COLOR_W_I  {sync, ch[N_CH-1]..ch[0]}.
REQ-010 vdata_valid_o  out  1  one-cycle strobe, complete pixel on vdata_o.
REQ-011 vdata_o  out  SYNC_W+N_CH*COLOR_W_O  {sync, corrected channels}, held between strobes.
REQ-012 pixel_drop_o  out  1  one-cycle pulse when an in-flight pixel is aborted.

Function
REQ-013 On vdata_valid_i the block SHALL latch gammaparams_i and sync bits and start an input channel counter at 0; the counter advances once per cycle up to N_CH-1 and then holds idle.
REQ-014 Channel k SHALL be registered into the table input at strobe cycle t+1+k, one channel per cycle, lowest index first.
REQ-015 The table sub-module SHALL have a fixed latency of 2 cycles: table output at t+3+k corresponds to channel k.
REQ-016 Selector decode: value GAMMA_TABLE_OFF = bypass; values below it select page = value; values above it select page = value-1 (3-bit page, 0..7); values above 8 SHALL select page 7.
REQ-017 Bypass SHALL output channel left-aligned: {ch, ch[COLOR_W_I-1 -: COLOR_W_O-COLOR_W_I]} (MSB replication); bypass path latency equals table latency.
REQ-018 Output collection SHALL place table result k into channel slot k of a staging register; sync bits travel through a delay line matched to this latency.
REQ-019 vdata_o SHALL update and vdata_valid_o SHALL pulse high for exactly one cycle at t+N_CH+3; no other cycle carries vdata_valid_o high.
REQ-020 A new vdata_valid_i while the input counter is below N_CH-1 SHALL abort the old pixel: no vdata_valid_o for it, pixel_drop_o high on the strobe cycle +1, new pixel processed normally from its strobe.
REQ-021 Strobes exactly N_CH cycles apart (back-to-back) SHALL be processed without loss; throughput one pixel per N_CH cycles.
REQ-022 gammaparams_i changes between strobes SHALL NOT affect a pixel already in flight.
REQ-023 Stage tags (pixel-valid, channel index) SHALL travel with data through the pipeline so the abort of REQ-020 suppresses only the aborted pixel's outputs.

Reset
REQ-024 While nRST low at a VCLK edge: vdata_o = 0, vdata_valid_o = 0, pixel_drop_o = 0, counters idle, delay lines and tags cleared, latched selector = GAMMA_TABLE_OFF.
REQ-025 Reset asserted mid-pixel SHALL discard it; first vdata_valid_o after release only follows a strobe seen after release.
REQ-026 Power-up register values SHALL equal reset values.

Structure
REQ-027 GAMMA_TABLE_OFF, selector width and table latency constant SHALL live in the shared video parameter header, not locally.
REQ-028 One sub-module gamma_table_v3 (VCLK, nRST, page, nbypass, data in/out, 2-cycle registered ROM) SHALL hold all table contents; gamma_module_v3 holds sequencing only.
REQ-029 Table latency SHALL be a header constant; gamma_module_v3 delay lines derive from it.

Verification
REQ-030 Bypass, defaults: selector=GAMMA_TABLE_OFF, strobe with ch0=7'h7F, ch1=7'h00, ch2=7'h40 -> at t+6 vdata_valid_o=1, channels 8'hFF, 8'h00, 8'h81, sync bits unchanged.
REQ-031 Page select: selector 0 and GAMMA_TABLE_OFF+1 on identical pixels -> both outputs equal the page-0 table entries (model lookup), one valid pulse each.
REQ-032 Back-to-back: 10 strobes every 3 cycles, random data -> 10 pulses every 3 cycles, each matching model; pixel_drop_o never high.
REQ-033 Abort: second strobe 1 cycle after first -> pixel_drop_o pulse once, exactly one vdata_valid_o at second strobe +6 carrying second pixel.
REQ-034 Reset mid-pixel: nRST low 1 cycle at t+2 -> all outputs 0 next cycle, no vdata_valid_o until a fresh strobe; that strobe yields output at +6.
REQ-035 Parameter sweep N_CH=4, COLOR_W_I=8, COLOR_W_O=10: bypass strobe all channels 8'hA5 -> at t+7 each channel 10'h296.
